// File: rtl/banked_ram_pkg.sv
// Shared types for the banked RAM: clear-sequencer FSM encoding and a
// constant-foldable log2 helper used to size the bank register.
package banked_ram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// Zero-fill sweep of the whole physical array, one word per cycle from address 0.
// Enters CLEAR while reset is held (when enabled) so busy covers reset and the full sweep.
module ram_clear_sequencer
   import banked_ram_pkg::*;
#(
   parameter int AW             = 10,
   parameter int CLEAR_ON_RESET = 0
) (
   input  logic          clk,
   input  logic          reset,
   output logic          busy,
   output logic [AW-1:0] clr_addr,
   output logic          clr_we
);

   localparam logic [AW-1:0] ONE = AW'(1);

   clr_state_e    state;
   clr_state_e    state_nxt;
   logic [AW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) cnt <= cnt + ONE;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      clr_we    = 1'b0;
      case (state)
         IDLE: ;
         CLEAR: begin
            busy   = 1'b1;
            clr_we = 1'b1;
            if (cnt == '1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign clr_addr = cnt;

endmodule

// File: rtl/banked_ram_memory.sv
// Banked single-port-per-direction RAM: registered read (1 cycle), per-bank write protect.
// No backpressure; all accesses are dropped while the zero-fill sweep is busy.
module banked_ram_memory
   import banked_ram_pkg::*;
#(
   parameter int    DATA_WIDTH     = 8,
   parameter int    ADDR_WIDTH     = 8,
   parameter int    BANKS          = 4,
   parameter string FILENAME       = "",
   parameter int    CLEAR_ON_RESET = 0,
   localparam int   BANK_BITS      = clog2(BANKS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd,
   input  logic                  we,
   input  logic                  bank_we,
   input  logic [BANK_BITS-1:0]  bank_in,
   input  logic                  wp_we,
   input  logic [BANKS-1:0]      wp_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  wp_err,
   output logic                  busy,
   output logic [BANK_BITS-1:0]  bank
);

   localparam int PA_WIDTH = BANK_BITS + ADDR_WIDTH;
   localparam int DEPTH    = BANKS << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [BANKS-1:0]      wp;
   logic [PA_WIDTH-1:0]   acc_addr;
   logic [PA_WIDTH-1:0]   clr_addr;
   logic                  clr_we;
   logic                  wr_ok;
   logic                  wr_blk;
   logic                  mem_we;
   logic [PA_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   ram_clear_sequencer #(
      .AW             (PA_WIDTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear (
      .clk      (clk),
      .reset    (reset),
      .busy     (busy),
      .clr_addr (clr_addr),
      .clr_we   (clr_we)
   );

   // bank and wp are the registered values, so same-cycle updates apply next access
   assign acc_addr  = {bank, addr};
   assign wr_ok     = we & ~busy & ~wp[bank];
   assign wr_blk    = we & ~busy & wp[bank];
   assign mem_we    = clr_we | wr_ok;
   assign mem_waddr = clr_we ? clr_addr : acc_addr;
   assign mem_wdata = clr_we ? '0 : data_in;

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= '0;
         rd_valid <= 1'b0;
         wp_err   <= 1'b0;
         bank     <= '0;
         wp       <= '0;
      end else begin
         rd_valid <= rd & ~busy;
         wp_err   <= wr_blk;
         if (rd && !busy) data_out <= mem[acc_addr];
         if (bank_we && !busy) bank <= bank_in;
         if (wp_we && !busy) wp <= wp_in;
      end
   end

endmodule

// File: tb/tb_banked_ram_memory.sv
// Directed bench: clear-on-reset instance checked against a reference array and a
// read scoreboard, plus a no-clear instance checking contents survive reset.
module tb_banked_ram_memory;

   logic       clk = 1'b0;
   logic       reset, rd, we, bank_we, wp_we;
   logic [7:0] addr, data_in, data_out;
   logic [1:0] bank_in, bank;
   logic [3:0] wp_in;
   logic       rd_valid, wp_err, busy;

   logic       reset_b, rd_b, we_b, bank_we_b, wp_we_b;
   logic [7:0] addr_b, data_in_b, data_out_b;
   logic [1:0] bank_in_b, bank_b;
   logic [3:0] wp_in_b;
   logic       rd_valid_b, wp_err_b, busy_b;

   int checks   = 0;
   int failures = 0;

   logic [7:0] model [1024];
   logic [1:0] bank_m;
   logic [3:0] wp_m;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   banked_ram_memory #(.CLEAR_ON_RESET(1)) dut (
      .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .rd(rd), .we(we),
      .bank_we(bank_we), .bank_in(bank_in), .wp_we(wp_we), .wp_in(wp_in),
      .data_out(data_out), .rd_valid(rd_valid), .wp_err(wp_err), .busy(busy), .bank(bank)
   );

   banked_ram_memory #(.CLEAR_ON_RESET(0)) dut_b (
      .clk(clk), .reset(reset_b), .addr(addr_b), .data_in(data_in_b), .rd(rd_b), .we(we_b),
      .bank_we(bank_we_b), .bank_in(bank_in_b), .wp_we(wp_we_b), .wp_in(wp_in_b),
      .data_out(data_out_b), .rd_valid(rd_valid_b), .wp_err(wp_err_b), .busy(busy_b), .bank(bank_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bank(input logic [1:0] b);
      bank_in = b; bank_we = 1'b1;
      cyc();
      bank_we = 1'b0; bank_m = b;
      chk("bank_reg", 32'(bank), 32'(b));
   endtask

   task automatic set_wp(input logic [3:0] m);
      wp_in = m; wp_we = 1'b1;
      cyc();
      wp_we = 1'b0; wp_m = m;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      logic blocked;
      blocked = wp_m[bank_m];
      if (!blocked) model[{bank_m, a}] = d;
      addr = a; data_in = d; we = 1'b1;
      cyc();
      we = 1'b0;
      chk("wp_err", 32'(wp_err), 32'(blocked));
      cyc();
      chk("wp_err_pulse", 32'(wp_err), 0);
   endtask

   task automatic do_read(input logic [7:0] a);
      logic [7:0] e;
      exp_q.push_back(model[{bank_m, a}]);
      addr = a; rd = 1'b1;
      cyc();
      rd = 1'b0;
      e = exp_q.pop_front();
      chk("rd_valid", 32'(rd_valid), 1);
      chk("rd_data", 32'(data_out), 32'(e));
      cyc();
      chk("rd_valid_drop", 32'(rd_valid), 0);
      chk("rd_hold", 32'(data_out), 32'(e));
   endtask

   initial begin
      int n;
      logic blocked;
      logic [7:0] e;
      {rd, we, bank_we, wp_we} = '0;
      addr = '0; data_in = '0; bank_in = '0; wp_in = '0;
      {rd_b, we_b, bank_we_b, wp_we_b} = '0;
      addr_b = '0; data_in_b = '0; bank_in_b = '0; wp_in_b = '0;
      bank_m = '0; wp_m = '0;
      reset = 1'b1; reset_b = 1'b1;
      #2;
      chk("rst_data_out", 32'(data_out), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_wp_err", 32'(wp_err), 0);
      chk("rst_bank", 32'(bank), 0);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_busy_noclear", 32'(busy_b), 0);
      cyc(); cyc();
      reset = 1'b0; reset_b = 1'b0;

      // strobes during the sweep must be ignored
      for (int i = 0; i < 500; i++) begin
         if (i == 10) begin
            rd = 1'b1; we = 1'b1; bank_we = 1'b1; bank_in = 2'd3; wp_we = 1'b1; wp_in = 4'hF;
         end
         if (i == 20) begin
            rd = 1'b0; we = 1'b0; bank_we = 1'b0; wp_we = 1'b0; wp_in = '0; bank_in = '0;
         end
         cyc();
         if (i > 10 && i <= 20) chk("busy_ignored", 32'({rd_valid, wp_err, bank}), 0);
      end
      chk("busy_mid", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("busy_in_reset", 32'(busy), 1);
      chk("midrst_data_out", 32'(data_out), 0);
      cyc();
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!busy) break;
         n++;
         cyc();
      end
      chk("busy_cycles", 32'(n), 1024);

      for (int i = 0; i < 1024; i++) model[i] = 8'h00;
      for (int b = 0; b < 4; b++) begin
         set_bank(2'(b));
         for (int a = 0; a < 256; a++) do_read(8'(a));
      end

      set_bank(2'd2);
      do_write(8'h10, 8'hA5);
      set_bank(2'd1);
      do_read(8'h10);
      set_bank(2'd2);
      do_read(8'h10);

      set_wp(4'b0100);
      do_write(8'h10, 8'h3C);
      do_read(8'h10);
      set_bank(2'd3);
      do_write(8'h10, 8'h5E);
      do_read(8'h10);

      // mask update and write in the same cycle: write sees the old mask
      blocked = wp_m[bank_m];
      if (!blocked) model[{bank_m, 8'h30}] = 8'h99;
      wp_in = 4'b1000; wp_we = 1'b1; addr = 8'h30; data_in = 8'h99; we = 1'b1;
      cyc();
      wp_we = 1'b0; we = 1'b0; wp_m = 4'b1000;
      chk("wp_same_cycle_err", 32'(wp_err), 32'(blocked));
      cyc();
      do_write(8'h31, 8'h44);
      do_read(8'h30);
      do_read(8'h31);

      set_wp(4'b0000);
      set_bank(2'd0);
      do_write(8'h20, 8'h11);
      exp_q.push_back(model[{bank_m, 8'h20}]);
      model[{bank_m, 8'h20}] = 8'h22;
      addr = 8'h20; data_in = 8'h22; rd = 1'b1; we = 1'b1;
      cyc();
      rd = 1'b0; we = 1'b0;
      e = exp_q.pop_front();
      chk("rbw_data", 32'(data_out), 32'(e));
      chk("rbw_valid", 32'(rd_valid), 1);
      cyc();
      do_read(8'h20);

      model[{bank_m, 8'h05}] = 8'h77;
      bank_in = 2'd3; bank_we = 1'b1; addr = 8'h05; data_in = 8'h77; we = 1'b1;
      cyc();
      bank_we = 1'b0; we = 1'b0; bank_m = 2'd3;
      chk("bank_same_cycle", 32'(bank), 3);
      do_read(8'h05);
      set_bank(2'd0);
      do_read(8'h05);

      // contents survive reset when clear-on-reset is disabled
      addr_b = 8'h03; data_in_b = 8'h5A; we_b = 1'b1;
      cyc();
      we_b = 1'b0; bank_in_b = 2'd1; bank_we_b = 1'b1;
      cyc();
      bank_we_b = 1'b0; addr_b = 8'h07; data_in_b = 8'hC3; we_b = 1'b1;
      cyc();
      we_b = 1'b0; reset_b = 1'b1;
      #1;
      chk("b_rst_busy", 32'(busy_b), 0);
      chk("b_rst_bank", 32'(bank_b), 0);
      chk("b_rst_data_out", 32'(data_out_b), 0);
      cyc();
      reset_b = 1'b0;
      addr_b = 8'h03; rd_b = 1'b1;
      cyc();
      rd_b = 1'b0;
      chk("b_busy_after", 32'(busy_b), 0);
      chk("b_keep_bank0", 32'(data_out_b), 32'h5A);
      chk("b_rd_valid", 32'(rd_valid_b), 1);
      bank_in_b = 2'd1; bank_we_b = 1'b1;
      cyc();
      bank_we_b = 1'b0; addr_b = 8'h07; rd_b = 1'b1;
      cyc();
      rd_b = 1'b0;
      chk("b_keep_bank1", 32'(data_out_b), 32'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
